// File: rtl/note_sample_streamer.sv
// note_sample_streamer: DDS sine feeder with attack/release envelope, one stereo sample per codec handshake
//
// Ports:
//   CLOCK_50                 in   system clock, rising edge
//   reset                    in   asynchronous active-high reset
//   note_on                  in   key held (level)
//   phase_inc                in   DDS tuning word, sampled on each accepted sample
//   rom_addr                 out  sine ROM address (top ADDR_W phase bits)
//   rom_data                 in   signed ROM word, valid one cycle after rom_addr
//   audio_out_allowed        in   codec FIFO has space
//   write_audio_out          out  one-cycle write strobe
//   left_channel_audio_out   out  signed scaled sample
//   right_channel_audio_out  out  same sample as left
//   envelope_gain            out  current envelope gain
module note_sample_streamer #(
    parameter int PHASE_W      = 32,
    parameter int ADDR_W       = 10,
    parameter int GAIN_W       = 8,
    parameter int ATTACK_STEP  = 4,
    parameter int RELEASE_STEP = 2
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              note_on,
    input  logic [PHASE_W-1:0] phase_inc,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              audio_out_allowed,
    output logic              write_audio_out,
    output logic [31:0]       left_channel_audio_out,
    output logic [31:0]       right_channel_audio_out,
    output logic [GAIN_W-1:0] envelope_gain
);
    typedef enum logic [1:0] {S_ADDR, S_DATA, S_WAIT} state_t;

    localparam logic [GAIN_W-1:0] GAIN_MAX = '1;
    localparam logic [GAIN_W:0]   ATK      = (GAIN_W+1)'(ATTACK_STEP);
    localparam logic [GAIN_W-1:0] REL      = GAIN_W'(RELEASE_STEP);

    state_t                   state;
    logic [PHASE_W-1:0]       phase, phase_next;
    logic [GAIN_W-1:0]        gain, gain_next;
    logic [GAIN_W:0]          gain_up;
    logic signed [32+GAIN_W:0] product;
    logic [31:0]              sample;

    always_comb begin
        gain_up    = {1'b0, gain} + ATK;
        gain_next  = note_on ? (gain_up > {1'b0, GAIN_MAX} ? GAIN_MAX : gain_up[GAIN_W-1:0])
                             : (gain < REL ? '0 : gain - REL);
        // a silent, released voice parks the phase so the next note starts at 0
        phase_next = (!note_on && gain == '0) ? '0 : phase + phase_inc;
        product    = $signed(rom_data) * $signed({1'b0, gain});
    end

    // combinational so an async reset in S_WAIT drops the strobe immediately
    assign write_audio_out         = (state == S_WAIT) && audio_out_allowed;
    assign left_channel_audio_out  = sample;
    assign right_channel_audio_out = sample;
    assign envelope_gain           = gain;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state    <= S_ADDR;
            phase    <= '0;
            gain     <= '0;
            rom_addr <= '0;
            sample   <= '0;
        end else begin
            case (state)
                S_ADDR: state <= S_DATA;
                S_DATA: begin
                    sample <= 32'(product >>> GAIN_W);
                    state  <= S_WAIT;
                end
                S_WAIT: if (audio_out_allowed) begin
                    phase    <= phase_next;
                    gain     <= gain_next;
                    // loaded with the new phase so the ROM holds it through S_ADDR
                    rom_addr <= phase_next[PHASE_W-1 -: ADDR_W];
                    state    <= S_ADDR;
                end
                default: state <= S_ADDR;
            endcase
        end
    end
endmodule

// File: tb/tb_note_sample_streamer.sv
// tb_note_sample_streamer: randomized self-checking bench against a sample-level envelope/DDS model
module tb_note_sample_streamer;
    logic        clk = 0;
    logic        rst;
    logic        note_on;
    logic [31:0] phase_inc;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data = 0;
    logic        allowed;
    logic        write;
    logic [31:0] left, right;
    logic [7:0]  gain;

    note_sample_streamer dut (
        .CLOCK_50(clk), .reset(rst), .note_on(note_on), .phase_inc(phase_inc),
        .rom_addr(rom_addr), .rom_data(rom_data), .audio_out_allowed(allowed),
        .write_audio_out(write), .left_channel_audio_out(left),
        .right_channel_audio_out(right), .envelope_gain(gain)
    );

    always #5 clk = ~clk;

    logic [31:0] rom_mem [1024];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int total = 0, bad = 0;
    logic [31:0] m_phase;
    int m_gain, m_since, n_writes, dut_writes;
    logic [31:0] seen0, seen256;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_sample(input logic [31:0] ph, input int g);
        longint p;
        p = longint'($signed(rom_mem[ph[31:22]])) * longint'(g);
        return 32'(p >>> 8);
    endfunction

    task automatic tick();
        logic acc;
        @(negedge clk);
        acc = (m_since >= 2) && allowed;
        chk("write", write, acc);
        chk("gain", gain, m_gain);
        chk("addr", rom_addr, m_phase[31:22]);
        if (m_since >= 2) begin
            chk("left", left, exp_sample(m_phase, m_gain));
            chk("right", right, exp_sample(m_phase, m_gain));
        end
        if (write) begin
            dut_writes++;
            if (gain == 8'd255 && rom_addr == 10'd0) seen0 = left;
            if (gain == 8'd255 && rom_addr == 10'd256) seen256 = left;
        end
        @(posedge clk);
        if (acc) begin
            n_writes++;
            if (note_on) begin
                m_gain  = m_gain + 4 > 255 ? 255 : m_gain + 4;
                m_phase = m_phase + phase_inc;
            end else if (m_gain == 0) m_phase = 0;
            else begin
                m_gain  = m_gain < 2 ? 0 : m_gain - 2;
                m_phase = m_phase + phase_inc;
            end
        end
        m_since = acc ? 0 : m_since + 1;
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_write"}, write, 0);
        chk({tag, "_addr"}, rom_addr, 0);
        chk({tag, "_gain"}, gain, 0);
        chk({tag, "_left"}, left, 0);
        chk({tag, "_right"}, right, 0);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;
        rom_mem[0]   = 32'h7FFF_FFFF;
        rom_mem[256] = 32'h8000_0000;
        rst = 1; note_on = 0; phase_inc = 0; allowed = 1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        m_phase = 0; m_gain = 0; m_since = 0; n_writes = 0; dut_writes = 0;
        rst = 0;
        // silent stream: strobes every third cycle, zero samples
        for (int i = 0; i < 9; i++) tick();
        chk("silent_writes", dut_writes, 3);
        // attack with quarter-turn phase steps
        note_on = 1; phase_inc = 32'h4000_0000;
        seen0 = 0; seen256 = 0;
        for (int i = 0; i < 76 * 3; i++) tick();
        chk("attack_sat", gain, 255);
        chk("full_pos", seen0, 32'h7F7F_FFFF);
        chk("full_neg", seen256, 32'h8080_0000);
        // stall in S_WAIT, then a single-cycle grant
        allowed = 0;
        for (int i = 0; i < 3; i++) tick();
        w0 = dut_writes;
        for (int i = 0; i < 20; i++) tick();
        chk("stall_no_strobe", dut_writes - w0, 0);
        allowed = 1; tick();
        allowed = 0; tick(); tick();
        chk("one_strobe", dut_writes - w0, 1);
        // release to silence, phase parks at zero
        allowed = 1; note_on = 0;
        for (int i = 0; i < 135 * 3; i++) tick();
        chk("release_zero", gain, 0);
        chk("release_phase", rom_addr, 0);
        // random envelope/tuning/backpressure
        for (int i = 0; i < 1500; i++) begin
            allowed = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 40) == 0) note_on = ~note_on;
            if ($urandom_range(0, 25) == 0) phase_inc = $urandom;
            tick();
        end
        // reset during an active strobe
        note_on = 1; allowed = 0;
        for (int i = 0; i < 3; i++) tick();
        allowed = 1;
        #1;
        chk("pre_reset_strobe", write, 1);
        rst = 1;
        #1;
        check_zero("mid_reset");
        m_phase = 0; m_gain = 0; m_since = 0;
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 30; i++) tick();
        chk("post_reset_gain", gain, 40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
